// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm engine.
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZED  = 2'd3
  } alarm_state_e;

  localparam logic [7:0] HOR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // Both nibbles must be decimal digits and the value must not exceed lim.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/alarm_multicanal_if.sv
// Bus bundle between the PicoBlaze/RTC side (master) and the alarm engine (slave).
interface alarm_multicanal_if #(
  parameter int unsigned N_CH = 4
);
  logic            tick_1hz;
  logic [7:0]      seg_bcd;
  logic [7:0]      min_bcd;
  logic [7:0]      hor_bcd;
  logic            wr_en;
  logic [2:0]      wr_ch;
  logic [7:0]      wr_hor;
  logic [7:0]      wr_min;
  logic            wr_arm;
  logic            ack;
  logic            snooze;
  logic            wr_err;
  logic [N_CH-1:0] armed_vec;
  logic [N_CH-1:0] ring_vec;
  logic [2:0]      ring_ch;
  logic            alarm_active;
  logic            alarm_blink;

  modport master (
    output tick_1hz, seg_bcd, min_bcd, hor_bcd, wr_en, wr_ch, wr_hor, wr_min, wr_arm, ack, snooze,
    input  wr_err, armed_vec, ring_vec, ring_ch, alarm_active, alarm_blink
  );

  modport slave (
    input  tick_1hz, seg_bcd, min_bcd, hor_bcd, wr_en, wr_ch, wr_hor, wr_min, wr_arm, ack, snooze,
    output wr_err, armed_vec, ring_vec, ring_ch, alarm_active, alarm_blink
  );
endinterface

// File: rtl/alarm_canal.sv
// One alarm channel: set-point registers, ring/snooze counters and the channel FSM.
module alarm_canal
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [7:0] seg_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hor_bcd,
  input  logic       wr_sel,
  input  logic [7:0] wr_hor,
  input  logic [7:0] wr_min,
  input  logic       wr_arm,
  input  logic       ack,
  input  logic       snooze,
  output logic       ring_nxt,
  output logic       armed_nxt
);

  localparam int unsigned RING_TC = RING_SECS - 1;
  localparam int unsigned SNZ_TC  = SNOOZE_MIN * 60 - 1;
  localparam int unsigned RING_W  = $clog2(RING_TC) + 1;
  localparam int unsigned SNZ_W   = $clog2(SNZ_TC) + 1;

  alarm_state_e      state_q, state_d;
  logic [7:0]        set_hor_q, set_hor_d, set_min_q, set_min_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic              match;

  // Qualified by seg==00 and a tick, so a match fires at most once per minute.
  assign match = tick_1hz && (seg_bcd == 8'h00) && (hor_bcd == set_hor_q) &&
                 (min_bcd == set_min_q);

  always_comb begin
    state_d    = state_q;
    set_hor_d  = set_hor_q;
    set_min_d  = set_min_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (wr_sel) begin
      set_hor_d  = wr_hor;
      set_min_d  = wr_min;
      state_d    = wr_arm ? ARMED : DISARMED;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      unique case (state_q)
        DISARMED: ;
        ARMED: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        RINGING: begin
          if (ack) begin
            state_d = ARMED;
          end else if (snooze) begin
            state_d   = SNOOZED;
            snz_cnt_d = '0;
          end else if (tick_1hz) begin
            if (ring_cnt_q == RING_W'(RING_TC)) state_d = ARMED;
            else ring_cnt_d = ring_cnt_q + RING_W'(1);
          end
        end
        SNOOZED: begin
          if (ack) begin
            state_d = ARMED;
          end else if (tick_1hz) begin
            if (snz_cnt_q == SNZ_W'(SNZ_TC)) begin
              state_d    = RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SNZ_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DISARMED;
      set_hor_q  <= 8'h00;
      set_min_q  <= 8'h00;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      set_hor_q  <= set_hor_d;
      set_min_q  <= set_min_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign ring_nxt  = (state_d == RINGING);
  assign armed_nxt = (state_d != DISARMED);

endmodule

// File: rtl/alarm_multicanal.sv
// N-channel alarm engine: write decode, per-channel FSMs, ringing priority encode, indicator.
// Define ALARM_BLINK_EN to make alarm_blink toggle per tick instead of following alarm_active.
module alarm_multicanal
  import alarm_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input logic               clk,
  input logic               reset,
  alarm_multicanal_if.slave bus
);

  logic            wr_ok;
  logic [N_CH-1:0] wr_sel, ring_d, armed_d;
  logic [N_CH-1:0] ring_q, armed_q;
  logic [2:0]      ring_ch_d, ring_ch_q;
  logic            wr_err_q, active_q;

  assign wr_ok = bus.wr_en && bcd_valid(bus.wr_hor, HOR_MAX) && bcd_valid(bus.wr_min, MIN_MAX) &&
                 (32'(bus.wr_ch) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_ok && (bus.wr_ch == 3'(i));

    alarm_canal #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_canal (
      .clk      (clk),
      .reset    (reset),
      .tick_1hz (bus.tick_1hz),
      .seg_bcd  (bus.seg_bcd),
      .min_bcd  (bus.min_bcd),
      .hor_bcd  (bus.hor_bcd),
      .wr_sel   (wr_sel[i]),
      .wr_hor   (bus.wr_hor),
      .wr_min   (bus.wr_min),
      .wr_arm   (bus.wr_arm),
      .ack      (bus.ack),
      .snooze   (bus.snooze),
      .ring_nxt (ring_d[i]),
      .armed_nxt(armed_d[i])
    );
  end

  // Lowest ringing index wins; scan downwards so the last hit is the lowest.
  always_comb begin
    ring_ch_d = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ring_d[i]) ring_ch_d = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_q  <= 1'b0;
      ring_q    <= '0;
      armed_q   <= '0;
      ring_ch_q <= '0;
      active_q  <= 1'b0;
    end else begin
      wr_err_q  <= bus.wr_en && !wr_ok;
      ring_q    <= ring_d;
      armed_q   <= armed_d;
      ring_ch_q <= ring_ch_d;
      active_q  <= |ring_d;
    end
  end

  assign bus.wr_err       = wr_err_q;
  assign bus.ring_vec     = ring_q;
  assign bus.armed_vec    = armed_q;
  assign bus.ring_ch      = ring_ch_q;
  assign bus.alarm_active = active_q;

`ifdef ALARM_BLINK_EN
  logic blink_q;

  // Starts high on entry, toggles per tick, cleared the cycle ringing stops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else if (!(|ring_d)) begin
      blink_q <= 1'b0;
    end else if (!active_q) begin
      blink_q <= 1'b1;
    end else if (bus.tick_1hz) begin
      blink_q <= ~blink_q;
    end
  end

  assign bus.alarm_blink = blink_q;
`else
  assign bus.alarm_blink = active_q;
`endif

endmodule

// File: tb/tb_alarm_multicanal.sv
// Self-checking bench for alarm_multicanal: directed scenarios plus a randomized run
// checked against a seconds/minutes-level reference model.
module tb_alarm_multicanal;

  localparam int unsigned N_CH       = 4;
  localparam int unsigned RING_SECS  = 60;
  localparam int unsigned SNOOZE_MIN = 5;
  localparam int          SNZ_TICKS  = SNOOZE_MIN * 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_multicanal_if #(.N_CH(N_CH)) bus ();

  alarm_multicanal #(
    .N_CH      (N_CH),
    .RING_SECS (RING_SECS),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int now_s  = 0;

  typedef enum int {M_OFF, M_ARM, M_RING, M_SNZ} mode_t;
  mode_t m_mode    [N_CH];
  int    m_set     [N_CH];
  int    ring_left [N_CH];
  int    snz_left  [N_CH];
  logic  exp_err;
  logic  exp_blink;

  function automatic int bcd2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int maxv);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd2i(v) <= maxv);
  endfunction

  function automatic logic [7:0] i2bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_ring();
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (m_mode[i] == M_RING);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_armed();
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (m_mode[i] != M_OFF);
    return r;
  endfunction

  function automatic logic [2:0] exp_ring_ch();
    logic [2:0] c = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) if (m_mode[i] == M_RING) c = 3'(i);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = M_OFF;
      m_set[i]  = 0;
    end
    exp_err   = 1'b0;
    exp_blink = 1'b0;
  endtask

  // Applies the inputs currently on the bus to the model, as the next clock edge will.
  task automatic model_edge();
    bit wr_ok, was_active, now_active;
    int tsec;
    wr_ok = bus.wr_en && bcd_ok(bus.wr_hor, 23) && bcd_ok(bus.wr_min, 59) &&
            (int'(bus.wr_ch) < N_CH);
    exp_err    = bus.wr_en && !wr_ok;
    was_active = |exp_ring();
    tsec = bcd2i(bus.hor_bcd) * 3600 + bcd2i(bus.min_bcd) * 60 + bcd2i(bus.seg_bcd);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (wr_ok && int'(bus.wr_ch) == ch) begin
        m_set[ch]  = bcd2i(bus.wr_hor) * 60 + bcd2i(bus.wr_min);
        m_mode[ch] = bus.wr_arm ? M_ARM : M_OFF;
      end else begin
        case (m_mode[ch])
          M_ARM: if (bus.tick_1hz && tsec == m_set[ch] * 60) begin
            m_mode[ch] = M_RING;
            ring_left[ch] = RING_SECS;
          end
          M_RING: begin
            if (bus.ack) m_mode[ch] = M_ARM;
            else if (bus.snooze) begin
              m_mode[ch]   = M_SNZ;
              snz_left[ch] = SNZ_TICKS;
            end else if (bus.tick_1hz) begin
              ring_left[ch]--;
              if (ring_left[ch] == 0) m_mode[ch] = M_ARM;
            end
          end
          M_SNZ: begin
            if (bus.ack) m_mode[ch] = M_ARM;
            else if (bus.tick_1hz) begin
              snz_left[ch]--;
              if (snz_left[ch] == 0) begin
                m_mode[ch]    = M_RING;
                ring_left[ch] = RING_SECS;
              end
            end
          end
          default: ;
        endcase
      end
    end
    now_active = |exp_ring();
`ifdef ALARM_BLINK_EN
    if (!now_active) exp_blink = 1'b0;
    else if (!was_active) exp_blink = 1'b1;
    else if (bus.tick_1hz) exp_blink = ~exp_blink;
`else
    exp_blink = now_active;
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.wr_en    = 1'b0;
    bus.ack      = 1'b0;
    bus.snooze   = 1'b0;
  endtask

  task automatic drive_time(input int t);
    bus.hor_bcd = i2bcd(t / 3600);
    bus.min_bcd = i2bcd((t / 60) % 60);
    bus.seg_bcd = i2bcd(t % 60);
  endtask

  task automatic do_tick(input int t);
    now_s = t % 86400;
    drive_time(now_s);
    bus.tick_1hz = 1'b1;
    step();
  endtask

  task automatic set_write(input int ch, input logic [7:0] h, input logic [7:0] m, input logic arm);
    bus.wr_ch  = 3'(ch);
    bus.wr_hor = h;
    bus.wr_min = m;
    bus.wr_arm = arm;
    bus.wr_en  = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ring_vec !== 4'b0000) begin errors++; $display("FAIL reset_ring_vec: got %b want 0000", bus.ring_vec); end
    checks++; if (bus.armed_vec !== 4'b0000) begin errors++; $display("FAIL reset_armed_vec: got %b want 0000", bus.armed_vec); end
    checks++; if (bus.ring_ch !== 3'd0) begin errors++; $display("FAIL reset_ring_ch: got %0d want 0", bus.ring_ch); end
    checks++; if (bus.alarm_active !== 1'b0 || bus.alarm_blink !== 1'b0 || bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: active=%b blink=%b err=%b want 0 0 0", bus.alarm_active, bus.alarm_blink, bus.wr_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_ring();
    set_write(1, 8'h07, 8'h30, 1'b1);
    step();
    checks++; if (bus.armed_vec !== 4'b0010 || bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL write_arm: armed=%b err=%b want 0010 0", bus.armed_vec, bus.wr_err);
    end
    do_tick(7 * 3600 + 29 * 60 + 59);
    checks++; if (bus.ring_vec !== 4'b0000) begin errors++; $display("FAIL pre_match: ring=%b want 0000", bus.ring_vec); end
    do_tick(7 * 3600 + 30 * 60);
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL match_ring_vec: got %b want 0010", bus.ring_vec); end
    checks++; if (bus.ring_ch !== 3'd1) begin errors++; $display("FAIL match_ring_ch: got %0d want 1", bus.ring_ch); end
    checks++; if (bus.alarm_active !== 1'b1 || bus.alarm_blink !== 1'b1) begin
      errors++; $display("FAIL match_active: active=%b blink=%b want 1 1", bus.alarm_active, bus.alarm_blink);
    end
  endtask

  task automatic test_ring_timeout();
    for (int k = 1; k < RING_SECS; k++) begin
      do_tick(now_s + 1);
`ifdef ALARM_BLINK_EN
      if (k <= 2) begin
        checks++; if (bus.alarm_blink !== ((k == 2) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL blink_toggle_%0d: got %b want %b", k, bus.alarm_blink, (k == 2));
        end
      end
`endif
    end
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL ring_tick59: got %b want 0010", bus.ring_vec); end
    do_tick(now_s + 1);
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0010) begin
      errors++; $display("FAIL ring_timeout: ring=%b armed=%b want 0000 0010", bus.ring_vec, bus.armed_vec);
    end
    checks++; if (bus.alarm_active !== 1'b0 || bus.alarm_blink !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: active=%b blink=%b want 0 0", bus.alarm_active, bus.alarm_blink);
    end
    for (int k = 0; k < 60; k++) do_tick(now_s + 1);
    checks++; if (bus.ring_vec !== 4'b0000) begin errors++; $display("FAIL no_rering: ring=%b want 0000", bus.ring_vec); end
  endtask

  task automatic test_snooze();
    do_tick(7 * 3600 + 30 * 60);
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL snz_ring: got %b want 0010", bus.ring_vec); end
    bus.snooze = 1'b1;
    step();
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec[1] !== 1'b1) begin
      errors++; $display("FAIL snoozed: ring=%b armed=%b want 0000 xx1x", bus.ring_vec, bus.armed_vec);
    end
    for (int k = 1; k < SNZ_TICKS; k++) do_tick(now_s + 1);
    checks++; if (bus.ring_vec !== 4'b0000) begin errors++; $display("FAIL snz_tick299: ring=%b want 0000", bus.ring_vec); end
    do_tick(now_s + 1);
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL snz_rering: ring=%b want 0010", bus.ring_vec); end
    bus.ack = 1'b1;
    step();
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0010) begin
      errors++; $display("FAIL snz_ack: ring=%b armed=%b want 0000 0010", bus.ring_vec, bus.armed_vec);
    end
  endtask

  task automatic test_bad_write();
    int         bch [4];
    logic [7:0] bh  [4];
    logic [7:0] bm  [4];
    bch = '{1, 1, 5, 2};
    bh  = '{8'h24, 8'h07, 8'h07, 8'h1A};
    bm  = '{8'h30, 8'h5A, 8'h30, 8'h00};
    for (int i = 0; i < 4; i++) begin
      set_write(bch[i], bh[i], bm[i], 1'b0);
      step();
      checks++; if (bus.wr_err !== 1'b1 || bus.armed_vec !== 4'b0010) begin
        errors++; $display("FAIL bad_write_%0d: err=%b armed=%b want 1 0010", i, bus.wr_err, bus.armed_vec);
      end
      step();
      checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL err_pulse_%0d: err=%b want 0", i, bus.wr_err); end
    end
    do_tick(7 * 3600 + 30 * 60);
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL setpoint_kept: ring=%b want 0010", bus.ring_vec); end
    bus.ack = 1'b1;
    step();
  endtask

  task automatic test_multi();
    set_write(0, 8'h12, 8'h00, 1'b1);
    step();
    set_write(2, 8'h12, 8'h00, 1'b1);
    step();
    do_tick(11 * 3600 + 59 * 60 + 59);
    do_tick(12 * 3600);
    checks++; if (bus.ring_vec !== 4'b0101 || bus.ring_ch !== 3'd0) begin
      errors++; $display("FAIL multi_ring: ring=%b ch=%0d want 0101 0", bus.ring_vec, bus.ring_ch);
    end
    bus.ack    = 1'b1;
    bus.snooze = 1'b1;
    step();
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0111) begin
      errors++; $display("FAIL ack_beats_snooze: ring=%b armed=%b want 0000 0111", bus.ring_vec, bus.armed_vec);
    end
  endtask

  task automatic test_write_priority();
    do_tick(12 * 3600);
    checks++; if (bus.ring_vec !== 4'b0101) begin errors++; $display("FAIL wp_ring: ring=%b want 0101", bus.ring_vec); end
    bus.ack = 1'b1;
    set_write(2, 8'h12, 8'h00, 1'b0);
    step();
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0011) begin
      errors++; $display("FAIL write_beats_ack: ring=%b armed=%b want 0000 0011", bus.ring_vec, bus.armed_vec);
    end
    set_write(3, 8'h12, 8'h01, 1'b1);
    do_tick(12 * 3600 + 60);
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b1011) begin
      errors++; $display("FAIL write_beats_match: ring=%b armed=%b want 0000 1011", bus.ring_vec, bus.armed_vec);
    end
  endtask

  task automatic test_reset_mid_ring();
    do_tick(7 * 3600 + 30 * 60);
    checks++; if (bus.ring_vec !== 4'b0010) begin errors++; $display("FAIL rst_pre_ring: ring=%b want 0010", bus.ring_vec); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0000 || bus.ring_ch !== 3'd0) begin
      errors++; $display("FAIL async_reset_vec: ring=%b armed=%b ch=%0d want 0000 0000 0", bus.ring_vec, bus.armed_vec, bus.ring_ch);
    end
    checks++; if (bus.alarm_active !== 1'b0 || bus.alarm_blink !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: active=%b blink=%b want 0 0", bus.alarm_active, bus.alarm_blink);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_tick(7 * 3600 + 29 * 60 + 59);
    do_tick(7 * 3600 + 30 * 60);
    checks++; if (bus.ring_vec !== 4'b0000 || bus.armed_vec !== 4'b0000) begin
      errors++; $display("FAIL post_reset_match: ring=%b armed=%b want 0000 0000", bus.ring_vec, bus.armed_vec);
    end
  endtask

  task automatic test_random();
    int cand_h [2];
    int cand_m [3];
    int r;
    cand_h = '{7, 12};
    cand_m = '{0, 30, 1};
    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 2 == 0) begin
        if ($urandom % 10 == 0) now_s = cand_h[$urandom % 2] * 3600 + cand_m[$urandom % 3] * 60;
        else now_s = (now_s + 1) % 86400;
        drive_time(now_s);
        bus.tick_1hz = 1'b1;
      end
      if ($urandom % 25 == 0) begin
        bus.wr_ch = 3'($urandom % 6);
        r = int'($urandom % 8);
        bus.wr_hor = (r == 0) ? 8'h24 : (r == 1) ? 8'h1A : i2bcd(cand_h[$urandom % 2]);
        r = int'($urandom % 8);
        bus.wr_min = (r == 0) ? 8'h5A : (r == 1) ? 8'h60 : i2bcd(cand_m[$urandom % 3]);
        bus.wr_arm = ($urandom % 4 != 0);
        bus.wr_en  = 1'b1;
      end
      if ($urandom % 50 == 0) bus.ack = 1'b1;
      if ($urandom % 20 == 0) bus.snooze = 1'b1;
      step();
      checks++; if (bus.ring_vec !== exp_ring()) begin errors++; $display("FAIL rnd_ring_vec n=%0d: got %b want %b", n, bus.ring_vec, exp_ring()); end
      checks++; if (bus.armed_vec !== exp_armed()) begin errors++; $display("FAIL rnd_armed_vec n=%0d: got %b want %b", n, bus.armed_vec, exp_armed()); end
      checks++; if (bus.ring_ch !== exp_ring_ch()) begin errors++; $display("FAIL rnd_ring_ch n=%0d: got %0d want %0d", n, bus.ring_ch, exp_ring_ch()); end
      checks++; if (bus.alarm_active !== (|exp_ring())) begin errors++; $display("FAIL rnd_active n=%0d: got %b want %b", n, bus.alarm_active, |exp_ring()); end
      checks++; if (bus.alarm_blink !== exp_blink) begin errors++; $display("FAIL rnd_blink n=%0d: got %b want %b", n, bus.alarm_blink, exp_blink); end
      checks++; if (bus.wr_err !== exp_err) begin errors++; $display("FAIL rnd_wr_err n=%0d: got %b want %b", n, bus.wr_err, exp_err); end
    end
  endtask

  initial begin
    bus.tick_1hz = 1'b0;
    bus.seg_bcd  = 8'h00;
    bus.min_bcd  = 8'h00;
    bus.hor_bcd  = 8'h00;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = 3'd0;
    bus.wr_hor   = 8'h00;
    bus.wr_min   = 8'h00;
    bus.wr_arm   = 1'b0;
    bus.ack      = 1'b0;
    bus.snooze   = 1'b0;
    test_reset();
    test_basic_ring();
    test_ring_timeout();
    test_snooze();
    test_bad_write();
    test_multi();
    test_write_priority();
    test_reset_mid_ring();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_multicanal.md
Name: alarm_multicanal

Overview:
- Parametrised N-channel alarm engine; successor to the single hard-wired alarm flag in the top level.
- Stores per-channel BCD hour/minute set-points written by the PicoBlaze port decoder.
- Compares them against RTC BCD time on each 1 Hz tick; runs a per-channel ring/snooze/acknowledge state machine.
- Drives the VGA alarm indicator and exposes which channel is ringing.

Parameters:
- N_CH, 4, number of independent alarm channels (1..8).
- RING_SECS, 60, ticks a channel rings before auto-stop.
- SNOOZE_MIN, 5, snooze duration in minutes (SNOOZE_MIN*60 ticks).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  single-cycle pulse once per RTC second
- seg_bcd  in  8  RTC seconds, BCD
- min_bcd  in  8  RTC minutes, BCD
- hor_bcd  in  8  RTC hours, BCD, 24 h
- wr_en  in  1  set-point write strobe, one cycle
- wr_ch  in  3  channel index for the write
- wr_hor  in  8  BCD hour to store
- wr_min  in  8  BCD minute to store
- wr_arm  in  1  1 = arm the channel, 0 = disarm it
- ack  in  1  acknowledge pulse (keyboard/PicoBlaze); stops all ringing or snoozed channels
- snooze  in  1  snooze pulse; applies to ringing channels only
- wr_err  out  1  one-cycle pulse on a rejected write
- armed_vec  out  N_CH  channel is in any state other than DISARMED
- ring_vec  out  N_CH  channel is in RINGING
- ring_ch  out  3  lowest index of a ringing channel; 0 when none
- alarm_active  out  1  OR of ring_vec; registered
- alarm_blink  out  1  indicator drive; see Optional Feature

Behaviour:
- Reset, asynchronous:
  - all channels DISARMED; set-points 8'h00.
  - all counters 0.
  - all outputs 0.
- Per-channel FSM, states DISARMED, ARMED, RINGING, SNOOZED:
  - ARMED -> RINGING on a tick where hor_bcd==set_hor, min_bcd==set_min and seg_bcd==8'h00. Ring counter loads 0.
  - RINGING -> ARMED on ack, or when the ring counter reaches RING_SECS-1 on a tick.
  - RINGING -> SNOOZED on snooze. Snooze counter loads 0.
  - SNOOZED -> RINGING when the snooze counter reaches SNOOZE_MIN*60-1 on a tick. Ring counter reloads 0.
  - SNOOZED -> ARMED on ack.
  - snooze while ARMED or DISARMED has no effect.
- Counters:
  - advance only on tick_1hz.
  - widths $clog2 of their terminal count + 1.
  - never wrap; terminal count forces the transition.
- Write handling, one clock latency:
  - wr_hor must be ≤ 8'h23 with both nibbles ≤ 9.
  - wr_min must be ≤ 8'h59 with both nibbles ≤ 9.
  - wr_ch must be < N_CH.
  - if any check fails: no state change; wr_err pulses on the next cycle.
  - a valid write loads the set-point and forces the channel to ARMED (wr_arm=1) or DISARMED (wr_arm=0). This also cancels RINGING or SNOOZED.
- Priorities, when events coincide in one cycle:
  - write beats ack.
  - ack beats snooze.
  - snooze beats timeout.
  - timeout beats a new match.
  - a write and a match on the same channel in the same cycle: the write wins, and the new set-point is compared from the next tick.
- Each match fires at most once per minute, because it is qualified by seg==00 and a tick. A channel re-armed during its matching second does not re-ring.
- Outputs:
  - ring_vec, armed_vec, alarm_active, ring_ch are registered; they reflect the state one cycle after the transition.
  - ring_ch is a priority encode of ring_vec.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined:
  - alarm_blink toggles on every tick_1hz while alarm_active=1.
  - alarm_blink is forced to 0 the cycle alarm_active falls; it starts at 1 on entry.
- Undefined:
  - alarm_blink = alarm_active; the toggle flop is not built.

Decomposition:
- Shared package alarm_pkg:
  - state enum (DISARMED=2'd0, ARMED=2'd1, RINGING=2'd2, SNOOZED=2'd3).
  - BCD limits 8'h23 and 8'h59.
  - function bcd_valid.
- One sub-module, alarm_canal:
  - contains one channel's FSM, set-point registers and counters.
  - instantiated N_CH times in a generate loop.
  - the top holds write decode, wr_err, priority encoder and the blink logic.

Test Plan:
- Write ch1 07:30 arm, time 07:29:59 -> 07:30:00 tick: ring_vec=4'b0010, ring_ch=1, alarm_active=1 one cycle after the tick.
- Ch1 ringing, no ack, 60 ticks: returns to ARMED at tick 60; ring_vec=0; no re-ring at 07:30:00 the next minute-wrap unless time matches again.
- Ch1 ringing, snooze pulse, then 300 ticks: SNOOZED (ring_vec=0, armed_vec[1]=1), rings again at tick 300; ack -> ARMED.
- Write hor=8'h24 or min=8'h5A or wr_ch=5 with N_CH=4: wr_err=1 for one cycle; set-points and armed_vec unchanged.
- Ch0 and ch2 both set to 12:00: both ring, ring_ch=0; ack and snooze in the same cycle -> both ARMED.
- Assert reset mid-RINGING: all outputs 0 immediately; no ring at the next match until rewritten. With ALARM_BLINK_EN, alarm_blink toggles 1,0,1 on successive ticks while ringing.
